// File: rtl/tour_resp_queue.sv
// Response generator and byte queue between the tour sequencer and the UART transmitter.
// One response byte is queued per completed move, and the bytes are drained to the UART one at a time.
module tour_resp_queue #(
  parameter int          NUM_MOVES = 24,
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  RESP_MID  = 8'h5A,
  parameter logic [7:0]  RESP_LAST = 8'hA5,
  localparam int         CW        = $clog2(NUM_MOVES + 1),
  localparam int         QW        = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tour_start_i,
  input  logic          move_done_i,
  input  logic          abort_i,
  input  logic          tx_done_i,
  output logic          trmt_o,
  output logic [7:0]    tx_data_o,
  output logic [CW-1:0] mv_cnt_o,
  output logic          tour_busy_o,
  output logic [QW-1:0] q_cnt_o,
  output logic          ovfl_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_MOVES - 1);
  localparam logic [CW-1:0] MOVES_MAX = CW'(NUM_MOVES);
  localparam logic [QW-1:0] Q_FULL    = QW'(DEPTH);

  typedef enum logic {T_IDLE, T_ACTIVE} tour_state_e;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;

  tour_state_e   tour_state_q, tour_state_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] mv_cnt_q, mv_cnt_d;
  logic          ovfl_q, ovfl_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW-1:0] q_cnt_q, q_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          trmt_q;
  logic [7:0]    mem_q [DEPTH];

  logic          push, pop, flush, do_push, q_full, q_empty;
  logic [7:0]    push_data;

  assign q_full  = (q_cnt_q == Q_FULL);
  assign q_empty = (q_cnt_q == '0);

  // Tour sequencing: abort beats a (re)start, which beats a move completion.
  always_comb begin
    tour_state_d = tour_state_q;
    mv_cnt_d     = mv_cnt_q;
    push         = 1'b0;
    push_data    = RESP_MID;
    flush        = 1'b0;
    if (abort_i) begin
      tour_state_d = T_IDLE;
      mv_cnt_d     = '0;
      flush        = 1'b1;
    end else if (tour_start_i) begin
      tour_state_d = T_ACTIVE;
      mv_cnt_d     = '0;
    end else if (move_done_i && (tour_state_q == T_ACTIVE)) begin
      push = 1'b1;
      if (mv_cnt_q == LAST_IDX) begin
        push_data    = RESP_LAST;
        tour_state_d = T_IDLE;
      end
      if (mv_cnt_q != MOVES_MAX) begin
        mv_cnt_d = mv_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!q_empty && !abort_i) begin
          pop        = 1'b1;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done_i) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // A push onto a full queue only survives if the head leaves in the same cycle.
  always_comb begin
    do_push   = push && (!q_full || pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    q_cnt_d   = q_cnt_q;
    tx_data_d = tx_data_q;
    ovfl_d    = ovfl_q;
    if (!abort_i && tour_start_i) begin
      ovfl_d = 1'b0;
    end else if (push && !do_push) begin
      ovfl_d = 1'b1;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      q_cnt_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        tx_data_d = mem_q[rd_ptr_q];
      end
      q_cnt_d = q_cnt_q + QW'(do_push) - QW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tour_state_q <= T_IDLE;
      tx_state_q   <= TX_IDLE;
      mv_cnt_q     <= '0;
      ovfl_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_cnt_q      <= '0;
      tx_data_q    <= 8'h00;
      trmt_q       <= 1'b0;
    end else begin
      tour_state_q <= tour_state_d;
      tx_state_q   <= tx_state_d;
      mv_cnt_q     <= mv_cnt_d;
      ovfl_q       <= ovfl_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      q_cnt_q      <= q_cnt_d;
      tx_data_q    <= tx_data_d;
      trmt_q       <= pop;
    end
  end

  assign trmt_o      = trmt_q;
  assign tx_data_o   = tx_data_q;
  assign mv_cnt_o    = mv_cnt_q;
  assign tour_busy_o = (tour_state_q == T_ACTIVE);
  assign q_cnt_o     = q_cnt_q;
  assign ovfl_o      = ovfl_q;

endmodule

// File: tb/tb_tour_resp_queue.sv
// Directed bench for tour_resp_queue: a 24-move instance and a 2-move instance with custom codes.
// Each instance has a small UART model that logs transmitted bytes and can answer with tx_done.
module tb_tour_resp_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       tourStartA = 1'b0, moveDoneA = 1'b0, abortA = 1'b0, txDoneManA = 1'b0;
  logic       txDoneAutoA = 1'b0;
  logic       trmtA, tourBusyA, ovflA;
  logic [7:0] txDataA;
  logic [4:0] mvCntA;
  logic [2:0] qCntA;

  logic       tourStartB = 1'b0, moveDoneB = 1'b0, abortB = 1'b0;
  logic       txDoneAutoB = 1'b0;
  logic       trmtB, tourBusyB, ovflB;
  logic [7:0] txDataB;
  logic [1:0] mvCntB;
  logic [2:0] qCntB;

  logic       autoA = 1'b0;
  int         timerA = 0, timerB = 0;
  logic [7:0] logA[$];
  logic [7:0] logB[$];

  int compared = 0;
  int mismatched = 0;
  int baseA;
  int midCount;

  always #5 clk = ~clk;

  tour_resp_queue dutA (
    .clk_i(clk), .rst_ni(rst_n),
    .tour_start_i(tourStartA), .move_done_i(moveDoneA), .abort_i(abortA),
    .tx_done_i(txDoneAutoA | txDoneManA),
    .trmt_o(trmtA), .tx_data_o(txDataA), .mv_cnt_o(mvCntA),
    .tour_busy_o(tourBusyA), .q_cnt_o(qCntA), .ovfl_o(ovflA)
  );

  tour_resp_queue #(.NUM_MOVES(2), .DEPTH(4), .RESP_MID(8'h11), .RESP_LAST(8'h22)) dutB (
    .clk_i(clk), .rst_ni(rst_n),
    .tour_start_i(tourStartB), .move_done_i(moveDoneB), .abort_i(abortB),
    .tx_done_i(txDoneAutoB),
    .trmt_o(trmtB), .tx_data_o(txDataB), .mv_cnt_o(mvCntB),
    .tour_busy_o(tourBusyB), .q_cnt_o(qCntB), .ovfl_o(ovflB)
  );

  // UART model for instance A: logs every trmt and, when enabled, answers 10 cycles later.
  always @(negedge clk) begin
    txDoneAutoA = 1'b0;
    if (!autoA) timerA = 0;
    if (timerA != 0) begin
      timerA = timerA - 1;
      if (timerA == 0) txDoneAutoA = 1'b1;
    end
    if (trmtA) begin
      logA.push_back(txDataA);
      if (autoA) timerA = 10;
    end
  end

  // UART model for instance B: always answers 3 cycles after trmt.
  always @(negedge clk) begin
    txDoneAutoB = 1'b0;
    if (timerB != 0) begin
      timerB = timerB - 1;
      if (timerB == 0) txDoneAutoB = 1'b1;
    end
    if (trmtB) begin
      logB.push_back(txDataB);
      timerB = 3;
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(2);
    checkOutput("rstTrmt", 32'(trmtA), 32'd0);
    checkOutput("rstTxData", 32'(txDataA), 32'h00);
    checkOutput("rstMvCnt", 32'(mvCntA), 32'd0);
    checkOutput("rstBusy", 32'(tourBusyA), 32'd0);
    checkOutput("rstQCnt", 32'(qCntA), 32'd0);
    checkOutput("rstOvfl", 32'(ovflA), 32'd0);
    rst_n = 1'b1;
    applyStimulus(2);

    // Full 24-move tour with 50-cycle move spacing and a responsive UART
    $display("[TB] full tour");
    autoA = 1'b1;
    baseA = logA.size();
    tourStartA = 1'b1; applyStimulus(1); tourStartA = 1'b0;
    checkOutput("startBusy", 32'(tourBusyA), 32'd1);
    checkOutput("startMvCnt", 32'(mvCntA), 32'd0);
    for (int i = 0; i < 24; i++) begin
      moveDoneA = 1'b1; applyStimulus(1); moveDoneA = 1'b0;
      if (i == 0) begin
        checkOutput("latQueued", 32'(qCntA), 32'd1);
        checkOutput("latNoTrmtYet", 32'(trmtA), 32'd0);
        applyStimulus(1);
        checkOutput("latTrmt", 32'(trmtA), 32'd1);
        checkOutput("latTxData", 32'(txDataA), 32'h5A);
        checkOutput("latPopped", 32'(qCntA), 32'd0);
        applyStimulus(1);
        checkOutput("trmtOneCycle", 32'(trmtA), 32'd0);
        applyStimulus(47);
      end else begin
        if (i == 22) begin
          checkOutput("busyBeforeLast", 32'(tourBusyA), 32'd1);
          checkOutput("mvCnt23", 32'(mvCntA), 32'd23);
        end
        if (i == 23) begin
          checkOutput("busyFallsOnLast", 32'(tourBusyA), 32'd0);
          checkOutput("mvCnt24", 32'(mvCntA), 32'd24);
        end
        applyStimulus(49);
      end
    end
    checkOutput("tourByteCount", 32'(logA.size() - baseA), 32'd24);
    midCount = 0;
    for (int i = 0; i < 23; i++) begin
      if (logA[baseA + i] === 8'h5A) midCount++;
    end
    checkOutput("tourMidBytes", 32'(midCount), 32'd23);
    checkOutput("tourLastByte", 32'(logA[baseA + 23]), 32'hA5);
    checkOutput("tourOvfl", 32'(ovflA), 32'd0);
    checkOutput("tourQEmpty", 32'(qCntA), 32'd0);

    // move_done while idle is ignored
    moveDoneA = 1'b1; applyStimulus(1); moveDoneA = 1'b0;
    applyStimulus(15);
    checkOutput("idleMvCnt", 32'(mvCntA), 32'd24);
    checkOutput("idleNoByte", 32'(logA.size() - baseA), 32'd24);
    checkOutput("idleQCnt", 32'(qCntA), 32'd0);

    // Burst of six moves with tx_done withheld
    $display("[TB] burst");
    autoA = 1'b0;
    applyStimulus(2);
    tourStartA = 1'b1; applyStimulus(1); tourStartA = 1'b0;
    baseA = logA.size();
    moveDoneA = 1'b1; applyStimulus(6); moveDoneA = 1'b0;
    checkOutput("burstQFull", 32'(qCntA), 32'd4);
    checkOutput("burstOvfl", 32'(ovflA), 32'd1);
    checkOutput("burstMvCnt", 32'(mvCntA), 32'd6);
    checkOutput("burstOneSent", 32'(logA.size() - baseA), 32'd1);
    checkOutput("burstByte", 32'(logA[baseA]), 32'h5A);
    tourStartA = 1'b1; applyStimulus(1); tourStartA = 1'b0;
    checkOutput("restartOvflClr", 32'(ovflA), 32'd0);
    checkOutput("restartMvCnt", 32'(mvCntA), 32'd0);
    checkOutput("restartQKept", 32'(qCntA), 32'd4);

    // Full queue: pop and push in the same cycle
    txDoneManA = 1'b1; applyStimulus(1); txDoneManA = 1'b0;
    moveDoneA = 1'b1; applyStimulus(1); moveDoneA = 1'b0;
    checkOutput("fullPushPopQ", 32'(qCntA), 32'd4);
    checkOutput("fullPushPopOvfl", 32'(ovflA), 32'd0);
    checkOutput("fullPushPopTrmt", 32'(trmtA), 32'd1);
    checkOutput("fullPushPopMv", 32'(mvCntA), 32'd1);

    // Abort with three queued and one in flight
    $display("[TB] abort");
    txDoneManA = 1'b1; applyStimulus(1); txDoneManA = 1'b0;
    applyStimulus(1);
    checkOutput("preAbortQ", 32'(qCntA), 32'd3);
    checkOutput("preAbortTrmt", 32'(trmtA), 32'd1);
    abortA = 1'b1; applyStimulus(1); abortA = 1'b0;
    checkOutput("abortQ", 32'(qCntA), 32'd0);
    checkOutput("abortBusy", 32'(tourBusyA), 32'd0);
    checkOutput("abortMvCnt", 32'(mvCntA), 32'd0);
    baseA = logA.size();
    applyStimulus(3);
    txDoneManA = 1'b1; applyStimulus(1); txDoneManA = 1'b0;
    applyStimulus(10);
    checkOutput("abortNoMoreTx", 32'(logA.size() - baseA), 32'd0);
    checkOutput("abortQStill0", 32'(qCntA), 32'd0);

    // Asynchronous reset while a byte is being sent
    $display("[TB] reset mid-transmission");
    tourStartA = 1'b1; applyStimulus(1); tourStartA = 1'b0;
    moveDoneA = 1'b1; applyStimulus(1); moveDoneA = 1'b0;
    applyStimulus(1);
    checkOutput("preRstTrmt", 32'(trmtA), 32'd1);
    baseA = logA.size();
    rst_n = 1'b0;
    #1;
    checkOutput("midRstTrmt", 32'(trmtA), 32'd0);
    checkOutput("midRstTxData", 32'(txDataA), 32'h00);
    checkOutput("midRstBusy", 32'(tourBusyA), 32'd0);
    checkOutput("midRstMvCnt", 32'(mvCntA), 32'd0);
    checkOutput("midRstQCnt", 32'(qCntA), 32'd0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(2);
    txDoneManA = 1'b1; applyStimulus(1); txDoneManA = 1'b0;
    applyStimulus(10);
    checkOutput("postRstNoTx", 32'(logA.size() - baseA), 32'd0);
    checkOutput("postRstTrmt", 32'(trmtA), 32'd0);

    // Two-move tour with custom response codes
    $display("[TB] short tour");
    tourStartB = 1'b1; applyStimulus(1); tourStartB = 1'b0;
    checkOutput("bBusy", 32'(tourBusyB), 32'd1);
    moveDoneB = 1'b1; applyStimulus(1); moveDoneB = 1'b0;
    applyStimulus(10);
    moveDoneB = 1'b1; applyStimulus(1); moveDoneB = 1'b0;
    checkOutput("bBusyFalls", 32'(tourBusyB), 32'd0);
    checkOutput("bMvCnt", 32'(mvCntB), 32'd2);
    applyStimulus(10);
    moveDoneB = 1'b1; applyStimulus(1); moveDoneB = 1'b0;
    applyStimulus(10);
    checkOutput("bByteCount", 32'(logB.size()), 32'd2);
    checkOutput("bFirstByte", 32'(logB[0]), 32'h11);
    checkOutput("bLastByte", 32'(logB[1]), 32'h22);
    checkOutput("bMvCntHeld", 32'(mvCntB), 32'd2);
    checkOutput("bOvfl", 32'(ovflB), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
